// File: rtl/c64_loader_pkg.sv
// Shared definitions for the C64 PRG loader: FSM states, BASIC pointer
// locations and helpers that map the pointer-phase index to address and data.
package c64_loader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HDR_LO = 3'd1,
        HDR_HI = 3'd2,
        DATA   = 3'd3,
        PTR    = 3'd4,
        DONE   = 3'd5
    } state_e;

    // Zero-page pointers that BASIC uses to find the end of the program.
    localparam logic [15:0] PTR_VARTAB  = 16'h002D;
    localparam logic [15:0] PTR_ARYTAB  = 16'h002F;
    localparam logic [15:0] PTR_STREND  = 16'h0031;
    localparam logic [15:0] PTR_LOADEND = 16'h00AE;

    // A PRG image starts with a little-endian 16-bit load address.
    localparam logic [1:0]  PRG_HDR_BYTES = 2'd2;

    // Index of the final write in the pointer phase (four lo/hi pairs).
    localparam logic [2:0]  PTR_LAST_IDX  = 3'd7;

    // Address of pointer-phase write idx: pairs in order, lo byte first.
    function automatic logic [15:0] ptr_addr(input logic [2:0] idx);
        logic [15:0] base;
        case (idx[2:1])
            2'd0:    base = PTR_VARTAB;
            2'd1:    base = PTR_ARYTAB;
            2'd2:    base = PTR_STREND;
            default: base = PTR_LOADEND;
        endcase
        return base + {15'd0, idx[0]};
    endfunction

    // Data of pointer-phase write idx: even index is the low byte.
    function automatic logic [7:0] ptr_byte(input logic [2:0] idx, input logic [15:0] value);
        return idx[0] ? value[15:8] : value[7:0];
    endfunction

endpackage

// File: rtl/prg_ram_writer.sv
// Streams a PRG image from the download port into C64 RAM. The two header
// bytes give the load address, the remaining bytes are written one at a time
// through a request/ack port, and optionally the BASIC end pointers are
// patched afterwards. A one-entry skid register absorbs a byte that arrives
// while a write is still outstanding.
module prg_ram_writer
    import c64_loader_pkg::*;
#(
    parameter int PTR_UPDATE = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load_prg,
    input  logic        ioctl_download,
    input  logic [22:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic        ioctl_wr,
    output logic        ioctl_wait,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_data,
    output logic        ram_we,
    input  logic        ram_ack,
    output logic [15:0] prg_start,
    output logic [15:0] prg_end,
    output logic        prg_done,
    output logic        prg_error
);

    state_e      state_r;
    logic        dl_prev_r;
    logic        ending_r;
    logic        pend_r;
    logic        skid_full_r;
    logic [7:0]  skid_data_r;
    logic        ovf_r;
    logic [15:0] cur_addr_r;
    logic [1:0]  hdr_cnt_r;
    logic [2:0]  ptr_idx_r;
    logic [15:0] ram_addr_r;
    logic [7:0]  ram_data_r;
    logic [15:0] prg_start_r;
    logic [15:0] prg_end_r;
    logic        prg_done_r;
    logic        prg_error_r;

    logic        dl_s;
    logic        end_s;
    logic        wr_s;
    logic        ack_s;
    logic        drained_s;
    logic        active_s;
    logic        ioctl_addr_unused_s;

    // The byte offset is implied by strobe order, so the address bus is not needed.
    assign ioctl_addr_unused_s = ^ioctl_addr;

    assign dl_s      = ioctl_download & load_prg;
    // Either input falling ends the stream; stay ended until IDLE is reached.
    assign end_s     = ending_r | ~dl_s;
    assign wr_s      = ioctl_wr & ~end_s;
    assign ack_s     = pend_r & ram_ack;
    assign drained_s = ~pend_r & ~skid_full_r;
    assign active_s  = (state_r == HDR_LO) || (state_r == HDR_HI) || (state_r == DATA);

    assign ioctl_wait = pend_r | skid_full_r | (state_r == PTR);
    assign ram_we     = pend_r;
    assign ram_addr   = ram_addr_r;
    assign ram_data   = ram_data_r;
    assign prg_start  = prg_start_r;
    assign prg_end    = prg_end_r;
    assign prg_done   = prg_done_r;
    assign prg_error  = prg_error_r;

    // Loader FSM with write handshake, skid register and pointer patching.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            dl_prev_r   <= 1'b0;
            ending_r    <= 1'b0;
            pend_r      <= 1'b0;
            skid_full_r <= 1'b0;
            skid_data_r <= 8'd0;
            ovf_r       <= 1'b0;
            cur_addr_r  <= 16'd0;
            hdr_cnt_r   <= 2'd0;
            ptr_idx_r   <= 3'd0;
            ram_addr_r  <= 16'd0;
            ram_data_r  <= 8'd0;
            prg_start_r <= 16'd0;
            prg_end_r   <= 16'd0;
            prg_done_r  <= 1'b0;
            prg_error_r <= 1'b0;
        end else begin
            dl_prev_r <= dl_s;

            case (state_r)
                IDLE: begin
                    prg_done_r <= 1'b0;
                    if (dl_s && !dl_prev_r) begin
                        state_r     <= HDR_LO;
                        ending_r    <= 1'b0;
                        skid_full_r <= 1'b0;
                        ovf_r       <= 1'b0;
                        hdr_cnt_r   <= 2'd0;
                        cur_addr_r  <= 16'd0;
                        prg_start_r <= 16'd0;
                        prg_error_r <= 1'b0;
                    end
                end

                HDR_LO: begin
                    if (wr_s) begin
                        prg_start_r[7:0] <= ioctl_data;
                        hdr_cnt_r        <= 2'd1;
                        state_r          <= HDR_HI;
                    end
                end

                HDR_HI: begin
                    if (wr_s) begin
                        prg_start_r[15:8] <= ioctl_data;
                        cur_addr_r        <= {ioctl_data, prg_start_r[7:0]};
                        hdr_cnt_r         <= PRG_HDR_BYTES;
                        state_r           <= DATA;
                    end
                end

                DATA: begin
                    if (ack_s) begin
                        pend_r     <= 1'b0;
                        cur_addr_r <= cur_addr_r + 16'd1;
                        if (cur_addr_r == 16'hFFFF) begin
                            ovf_r <= 1'b1;
                        end
                    end
                    if (!pend_r && skid_full_r) begin
                        // Skid byte goes first; a new strobe refills the skid.
                        if (ovf_r) begin
                            prg_error_r <= 1'b1;
                        end else begin
                            pend_r     <= 1'b1;
                            ram_addr_r <= cur_addr_r;
                            ram_data_r <= skid_data_r;
                        end
                        if (wr_s) begin
                            skid_data_r <= ioctl_data;
                        end else begin
                            skid_full_r <= 1'b0;
                        end
                    end else if (!pend_r && wr_s) begin
                        if (ovf_r) begin
                            prg_error_r <= 1'b1;
                        end else begin
                            pend_r     <= 1'b1;
                            ram_addr_r <= cur_addr_r;
                            ram_data_r <= ioctl_data;
                        end
                    end else if (pend_r && wr_s && !skid_full_r) begin
                        skid_full_r <= 1'b1;
                        skid_data_r <= ioctl_data;
                    end
                end

                PTR: begin
                    if (ack_s) begin
                        pend_r <= 1'b0;
                        if (ptr_idx_r == PTR_LAST_IDX) begin
                            state_r    <= DONE;
                            prg_done_r <= 1'b1;
                        end else begin
                            ptr_idx_r <= ptr_idx_r + 3'd1;
                        end
                    end else if (!pend_r) begin
                        pend_r     <= 1'b1;
                        ram_addr_r <= ptr_addr(ptr_idx_r);
                        ram_data_r <= ptr_byte(ptr_idx_r, prg_end_r);
                    end
                end

                DONE: begin
                    prg_done_r <= 1'b0;
                    state_r    <= IDLE;
                end

                default: begin
                    state_r    <= IDLE;
                    pend_r     <= 1'b0;
                    prg_done_r <= 1'b0;
                end
            endcase

            // End of stream: latch it, then finish once every byte is written.
            if (active_s && end_s) begin
                ending_r <= 1'b1;
                if (drained_s) begin
                    prg_end_r <= cur_addr_r;
                    if (hdr_cnt_r < PRG_HDR_BYTES) begin
                        prg_error_r <= 1'b1;
                        prg_done_r  <= 1'b1;
                        state_r     <= DONE;
                    end else if (PTR_UPDATE != 32'sd0) begin
                        ptr_idx_r <= 3'd0;
                        state_r   <= PTR;
                    end else begin
                        prg_done_r <= 1'b1;
                        state_r    <= DONE;
                    end
                end
            end
        end
    end

endmodule

// File: doc/prg_ram_writer.md
PRG_RAM_WRITER -- requirements
Module: prg_ram_writer

Interface
REQ-001 Parameter PTR_UPDATE, default 1, 1 = write BASIC end pointers after load, 0 = skip the pointer phase.
REQ-002 clk  in  1  sole clock; all logic on its rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 load_prg  in  1  high while a PRG image is being streamed.
REQ-005 ioctl_download  in  1  download window; high for the whole stream.
REQ-006 ioctl_addr  in  23  byte offset of the current byte within the image.
REQ-007 ioctl_data  in  8  image byte; valid in the cycle ioctl_wr is high.
REQ-008 ioctl_wr  in  1  one-cycle byte strobe.
REQ-009 ioctl_wait  out  1  backpressure to the upstream loader.
REQ-010 ram_addr  out  16  C64 RAM write address.
REQ-011 ram_data  out  8  C64 RAM write data.
REQ-012 ram_we  out  1  write request; held until ram_ack.
REQ-013 ram_ack  in  1  one-cycle completion of the pending write.
REQ-014 prg_start  out  16  load address taken from the header.
REQ-015 prg_end  out  16  last written address + 1.
REQ-016 prg_done  out  1  one-cycle pulse at the end of the load.
REQ-017 prg_error  out  1  sticky flag: short image or address overflow; cleared at the next load start.

Function
REQ-018 FSM states: IDLE, HDR_LO, HDR_HI, DATA, PTR, DONE.
REQ-019 IDLE -> HDR_LO on the rising edge of (ioctl_download & load_prg); ioctl_wr is ignored in IDLE.
REQ-020 HDR_LO: the first strobed byte goes to prg_start[7:0], then HDR_HI.
REQ-021 HDR_HI: the next byte goes to prg_start[15:8]; cur_addr is loaded with the full 16-bit address, then DATA.
REQ-022 DATA: each strobed byte drives ram_addr=cur_addr and ram_data=byte with ram_we=1 until ram_ack.
REQ-023 After each ram_ack, cur_addr increments by 1.
REQ-024 ram_we de-asserts in the cycle after ram_ack; only one write is outstanding at a time.
REQ-025 A one-entry skid register captures a byte strobed while a write is pending; no byte is ever lost or duplicated.
REQ-026 ioctl_wait = write pending OR skid register full; it is asserted combinationally from registered state.
REQ-027 Overflow: once a write to $FFFF completes, further bytes are dropped (no ram_we), prg_error=1, and prg_end stays $0000 (wrap).
REQ-028 On the falling edge of ioctl_download, the FSM drains pending and skid writes first.
REQ-029 After draining, prg_end is set to cur_addr.
REQ-030 If fewer than 2 bytes were received, prg_error=1 and the FSM goes to DONE with no RAM writes.
REQ-031 Otherwise the FSM goes to PTR if PTR_UPDATE=1, else to DONE.
REQ-032 PTR: eight sequential handshaked writes of prg_end lo/hi to $002D/$002E, $002F/$0030, $0031/$0032, $00AE/$00AF, in that order.
REQ-033 ioctl_wait stays high throughout PTR.
REQ-034 DONE: prg_done=1 for one cycle, then IDLE.
REQ-035 A new download rising edge in any state other than IDLE is ignored until IDLE is reached.
REQ-036 If load_prg falls mid-stream, this is treated as the end of the download (same as REQ-028..REQ-031).
REQ-037 Latency from ioctl_wr to ram_we is 1 cycle when idle.

Reset
REQ-038 With reset_n low: FSM=IDLE; ram_we, ioctl_wait, prg_done, prg_error = 0; ram_addr, ram_data, prg_start, prg_end, cur_addr = 0; skid register empty.
REQ-039 Reset asserted mid-write aborts immediately; a late ram_ack after reset is ignored.

Structure
REQ-040 The package c64_loader_pkg holds the state enum, the four pointer address constants, and PRG_HDR_BYTES=2.
REQ-041 The module has no sub-modules; the skid register is inline.

Verification
REQ-042 Image 01 08 AA BB CC, ram_ack 2 cycles after ram_we -> writes $0801=AA, $0802=BB, $0803=CC; prg_start=$0801, prg_end=$0804; pointer pairs = 04 08; one prg_done pulse.
REQ-043 ioctl_wr on consecutive-byte timing against a 6-cycle ram_ack -> ioctl_wait high and the skid register is used; the RAM write trace is exactly equal to the input byte order.
REQ-044 Image FE FF 11 22 33 -> $FFFE=11, $FFFF=22; 33 dropped; prg_error=1; prg_end=$0000.
REQ-045 Image of 1 byte -> no RAM writes; prg_error=1; prg_done pulse.
REQ-046 reset_n low during the 3rd data write -> ram_we=0 in the same cycle; state IDLE.
REQ-047 PTR_UPDATE=0 with the image from REQ-042 -> no writes below $0100; prg_done asserted 1 cycle after the last data ack drains.
